riscv_pipe_top: RTL and testbench
=================================

RISCV_PIPE_TOP -- requirements
Module: riscv_pipe_top

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 256, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 256, meaning data memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have no other ports; state is observed by hierarchical reference only.

Function
REQ-006 SHALL implement a 5-stage in-order RV32I-subset pipeline: IF, ID, EX, MEM, WB.
REQ-007 Supported instructions SHALL be exactly these:
- R-type: ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, SRA.
- I-type: ADDI, ANDI, ORI, XORI, SLTI.
- Memory and control: LW, SW, BEQ, BNE, JAL, LUI.
- Any other encoding SHALL execute as a NOP.
REQ-008 Instruction memory SHALL be an instance named INST1 holding array mem[0:IMEM_WORDS-1] of 32-bit words.
REQ-009 Fetch SHALL read mem[PC[31:2]] combinationally; mem[0] SHALL be the instruction at PC 0.
REQ-010 PC SHALL increment by 4 each unstalled cycle; PC bits [1:0] SHALL always be 0.
REQ-011 Data memory SHALL be word-addressed by ALU result [31:2]:
- synchronous write in MEM;
- combinational read in MEM;
- index taken modulo DMEM_WORDS.
REQ-012 Register file SHALL have 32x32 entries with x0 reading 0 and writes to x0 ignored.
REQ-013 A register write in WB SHALL be visible to the ID read in the same cycle (internal bypass).
REQ-014 EX operand forwarding SHALL use EX/MEM result when EX/MEM.rd matches the source register and rd != 0.
REQ-015 Otherwise EX operand forwarding SHALL use MEM/WB result when MEM/WB.rd matches and rd != 0.
REQ-016 When both EX/MEM and MEM/WB match, EX/MEM (younger) SHALL take priority.
REQ-017 SW store data SHALL be forwarded by the same rules.
REQ-018 Load-use hazard (LW in EX whose rd is a source of the ID instruction) SHALL cause:
- exactly one stall cycle;
- PC and IF/ID held;
- a bubble inserted into ID/EX.
REQ-019 Branches and JAL SHALL resolve in EX.
REQ-020 On a taken branch or JAL, PC SHALL become EX.PC + immediate, and the IF/ID and ID/EX instructions SHALL be flushed to NOPs (2-cycle penalty).
REQ-021 JAL SHALL write EX.PC + 4 to rd.
REQ-022 Shift amounts SHALL use the low 5 bits; SLT and SLTI SHALL compare signed.
REQ-023 Arithmetic SHALL wrap modulo 2^32.
REQ-024 A stall and a taken branch in the same cycle: the redirect SHALL win and the stall SHALL be dropped.

Reset
REQ-025 While rst=1 at a clock edge:
- PC SHALL become 0;
- every pipeline register SHALL become a NOP (0x00000013, no write-back);
- all registers x1-x31 SHALL become 0.
REQ-026 Reset SHALL NOT alter instruction or data memory contents.
REQ-027 The first fetch after rst deasserts SHALL be from PC 0.
REQ-028 Reset asserted mid-program SHALL abandon all in-flight instructions with no further register or memory writes.

Structure
REQ-029 A shared package SHALL hold:
- opcode, funct3 and funct7 constants;
- the ALU-op enum;
- the NOP constant;
- the forward-select enum (NONE, EXMEM, MEMWB).
REQ-030 The only sub-module SHALL be the instruction memory (module imem, instance INST1); all other logic SHALL be inline.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset: rst high 2 cycles, then ADDI x1,x0,5 -> x1=5 at 5th cycle after release.
- Forwarding priority: ADDI x1,x0,1; ADDI x1,x0,2; ADD x2,x1,x1 -> x2=4 (EX/MEM beats MEM/WB), not 2.
- MEM/WB forwarding: ADDI x3,x0,7; NOP; ADD x4,x3,x3 -> x4=14.
- Load-use: ADDI x5,x0,9; SW x5,0(x0); LW x6,0(x0); ADD x7,x6,x6 -> x7=18, exactly one stall cycle.
- Branch flush: ADDI x8,x0,1; BEQ x8,x8,+12; ADDI x9,x0,1; ADDI x9,x0,2; ADDI x10,x0,3 -> x9=0, x10=3.
- JAL: JAL x1,+8 at PC 0 -> x1=4, instruction at PC 4 never writes.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the riscv_pipe_top 5-stage RV32I-subset pipeline.
// Contents: opcode/funct3/funct7 constants, ALU-op and forward-select enums,
// the canonical NOP encoding, pipeline-register layouts and the ALU function.
package riscv_pipe_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SR      = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;
  localparam logic [2:0] F3_LW      = 3'd2;
  localparam logic [2:0] F3_SW      = 3'd2;
  localparam logic [2:0] F3_BEQ     = 3'd0;
  localparam logic [2:0] F3_BNE     = 3'd1;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ADDI x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  typedef enum logic [1:0] {FWD_NONE, FWD_EXMEM, FWD_MEMWB} fwd_sel_t;

  // An all-zero ID/EX entry is a bubble: no write-back, no memory access,
  // no control transfer -- the architectural effect of NOP_INSTR.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;        // 0 for instructions that do not write back
    alu_op_t     alu_op;
    logic        use_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_beq;
    logic        is_bne;
    logic        is_jal;
    logic        is_lui;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] result;    // write-back value, or address for LW/SW
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_wb_t;

  function automatic logic [31:0] alu_compute(input alu_op_t op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SRA: return $unsigned($signed(a) >>> b[4:0]);
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/imem.sv
// Instruction memory: IMEM_WORDS x 32-bit words, combinational read.
// Contents are preloaded by hierarchical reference; no reset, no write port.
// Ports: idx   - word index (PC[31:2] reduced modulo depth)
//        instr - instruction word at idx
module imem #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned IDX_W      = 8
) (
  input  logic [IDX_W-1:0] idx,
  output logic [31:0]      instr
);

  logic [31:0] mem [0:IMEM_WORDS-1];

  assign instr = mem[idx];

endmodule

// File: rtl/riscv_pipe_top.sv
// riscv_pipe_top: 5-stage in-order RV32I-subset pipeline (IF ID EX MEM WB).
// Supported: ADD SUB AND OR XOR SLT SLL SRL SRA, ADDI ANDI ORI XORI SLTI,
// LW SW BEQ BNE JAL LUI; every other encoding behaves as a NOP.
// Forwarding EX/MEM > MEM/WB into EX, WB->ID register-file bypass,
// one-cycle load-use stall, branches/JAL resolved in EX with 2-cycle flush.
// Ports: clk - clock, rising edge
//        rst - synchronous active-high reset
// State (pc, regs, dmem, INST1.mem) is observed hierarchically.
module riscv_pipe_top #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256
) (
  input logic clk,
  input logic rst
);
  import riscv_pipe_pkg::*;

  localparam int unsigned IA = $clog2(IMEM_WORDS);
  localparam int unsigned DA = $clog2(DMEM_WORDS);

  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  id_ex_t      id_ex;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;
  logic [31:0] regs [0:31];
  logic [31:0] dmem [0:DMEM_WORDS-1];

  // ---------------- IF ----------------
  logic [IA-1:0] imem_idx;
  logic [31:0]   fetch_instr;

  assign imem_idx = IA'(pc[31:2] % 30'(IMEM_WORDS));

  imem #(
    .IMEM_WORDS(IMEM_WORDS),
    .IDX_W     (IA)
  ) INST1 (
    .idx  (imem_idx),
    .instr(fetch_instr)
  );

  // ---------------- ID ----------------
  logic [6:0]  id_opcode;
  logic [2:0]  id_f3;
  logic [6:0]  id_f7;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  id_ex_t      dec;
  logic        use_rs1, use_rs2, dec_valid;

  assign id_opcode = if_id_instr[6:0];
  assign id_rd     = if_id_instr[11:7];
  assign id_f3     = if_id_instr[14:12];
  assign id_rs1    = if_id_instr[19:15];
  assign id_rs2    = if_id_instr[24:20];
  assign id_f7     = if_id_instr[31:25];

  assign imm_i = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
  assign imm_s = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
  assign imm_b = {{19{if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                  if_id_instr[30:25], if_id_instr[11:8], 1'b0};
  assign imm_j = {{11{if_id_instr[31]}}, if_id_instr[31], if_id_instr[19:12],
                  if_id_instr[20], if_id_instr[30:21], 1'b0};
  assign imm_u = {if_id_instr[31:12], 12'b0};

  assign wb_we   = mem_wb.reg_write;
  assign wb_rd   = mem_wb.rd;
  assign wb_data = mem_wb.result;

  // Register read with same-cycle WB bypass
  assign rf_rd1 = (id_rs1 == 5'd0) ? '0 :
                  (wb_we && wb_rd == id_rs1) ? wb_data : regs[id_rs1];
  assign rf_rd2 = (id_rs2 == 5'd0) ? '0 :
                  (wb_we && wb_rd == id_rs2) ? wb_data : regs[id_rs2];

  always_comb begin
    dec         = '0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    dec_valid   = 1'b1;
    dec.pc      = if_id_pc;
    dec.rs1     = id_rs1;
    dec.rs2     = id_rs2;
    dec.rs1_val = rf_rd1;
    dec.rs2_val = rf_rd2;
    case (id_opcode)
      OP_R: begin
        case ({id_f7, id_f3})
          {F7_BASE, F3_ADD_SUB}: dec.alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD_SUB}: dec.alu_op = ALU_SUB;
          {F7_BASE, F3_SLL}:     dec.alu_op = ALU_SLL;
          {F7_BASE, F3_SLT}:     dec.alu_op = ALU_SLT;
          {F7_BASE, F3_XOR}:     dec.alu_op = ALU_XOR;
          {F7_BASE, F3_SR}:      dec.alu_op = ALU_SRL;
          {F7_ALT,  F3_SR}:      dec.alu_op = ALU_SRA;
          {F7_BASE, F3_OR}:      dec.alu_op = ALU_OR;
          {F7_BASE, F3_AND}:     dec.alu_op = ALU_AND;
          default:               dec_valid  = 1'b0;
        endcase
        if (dec_valid) begin
          dec.reg_write = 1'b1;
          dec.rd        = id_rd;
          use_rs1       = 1'b1;
          use_rs2       = 1'b1;
        end
      end
      OP_I: begin
        case (id_f3)
          F3_ADD_SUB: dec.alu_op = ALU_ADD;
          F3_SLT:     dec.alu_op = ALU_SLT;
          F3_XOR:     dec.alu_op = ALU_XOR;
          F3_OR:      dec.alu_op = ALU_OR;
          F3_AND:     dec.alu_op = ALU_AND;
          default:    dec_valid  = 1'b0;
        endcase
        if (dec_valid) begin
          dec.reg_write = 1'b1;
          dec.rd        = id_rd;
          dec.use_imm   = 1'b1;
          dec.imm       = imm_i;
          use_rs1       = 1'b1;
        end
      end
      OP_LOAD: if (id_f3 == F3_LW) begin
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.rd        = id_rd;
        dec.use_imm   = 1'b1;
        dec.imm       = imm_i;
        use_rs1       = 1'b1;
      end
      OP_STORE: if (id_f3 == F3_SW) begin
        dec.mem_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm       = imm_s;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_BRANCH: if (id_f3 == F3_BEQ || id_f3 == F3_BNE) begin
        dec.is_beq = (id_f3 == F3_BEQ);
        dec.is_bne = (id_f3 == F3_BNE);
        dec.imm    = imm_b;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OP_JAL: begin
        dec.is_jal    = 1'b1;
        dec.reg_write = 1'b1;
        dec.rd        = id_rd;
        dec.imm       = imm_j;
      end
      OP_LUI: begin
        dec.is_lui    = 1'b1;
        dec.reg_write = 1'b1;
        dec.rd        = id_rd;
        dec.imm       = imm_u;
      end
      default: ;
    endcase
  end

  // ---------------- EX ----------------
  fwd_sel_t    fwd_a, fwd_b;
  logic [31:0] op_a, op_b_reg, alu_b, alu_out, ex_result, br_target;
  logic [31:0] mem_result;
  logic        redirect, load_use, stall;

  always_comb begin
    fwd_a = FWD_NONE;
    if (ex_mem.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs1)
      fwd_a = FWD_EXMEM;
    else if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs1)
      fwd_a = FWD_MEMWB;
    fwd_b = FWD_NONE;
    if (ex_mem.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs2)
      fwd_b = FWD_EXMEM;
    else if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs2)
      fwd_b = FWD_MEMWB;
  end

  always_comb begin
    case (fwd_a)
      FWD_EXMEM: op_a = ex_mem.result;
      FWD_MEMWB: op_a = mem_wb.result;
      default:   op_a = id_ex.rs1_val;
    endcase
    case (fwd_b)
      FWD_EXMEM: op_b_reg = ex_mem.result;
      FWD_MEMWB: op_b_reg = mem_wb.result;
      default:   op_b_reg = id_ex.rs2_val;
    endcase
  end

  assign alu_b     = id_ex.use_imm ? id_ex.imm : op_b_reg;
  assign alu_out   = alu_compute(id_ex.alu_op, op_a, alu_b);
  assign ex_result = id_ex.is_jal ? (id_ex.pc + 32'd4) :
                     id_ex.is_lui ? id_ex.imm : alu_out;
  assign br_target = id_ex.pc + id_ex.imm;
  assign redirect  = id_ex.is_jal ||
                     (id_ex.is_beq && op_a == op_b_reg) ||
                     (id_ex.is_bne && op_a != op_b_reg);

  assign load_use = id_ex.mem_read && id_ex.rd != 5'd0 &&
                    ((use_rs1 && id_ex.rd == id_rs1) ||
                     (use_rs2 && id_ex.rd == id_rs2));
  // The redirect flushes the ID instruction, so its stall is moot
  assign stall = load_use && !redirect;

  // ---------------- MEM ----------------
  logic [DA-1:0] dmem_idx;

  assign dmem_idx   = DA'(ex_mem.result[31:2] % 30'(DMEM_WORDS));
  assign mem_result = ex_mem.mem_read ? dmem[dmem_idx] : ex_mem.result;

  // Store is gated by rst so an in-flight SW is abandoned on reset
  always_ff @(posedge clk) begin
    if (!rst && ex_mem.mem_write)
      dmem[dmem_idx] <= ex_mem.store_data;
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      id_ex       <= '0;
      ex_mem      <= '0;
      mem_wb      <= '0;
      for (int unsigned i = 0; i < 32; i++)
        regs[i] <= '0;
    end else begin
      if (redirect) begin
        pc          <= {br_target[31:2], 2'b00};
        if_id_instr <= NOP_INSTR;
        if_id_pc    <= '0;
        id_ex       <= '0;
      end else if (stall) begin
        id_ex       <= '0;
      end else begin
        pc          <= pc + 32'd4;
        if_id_instr <= fetch_instr;
        if_id_pc    <= pc;
        id_ex       <= dec;
      end

      ex_mem.result     <= ex_result;
      ex_mem.store_data <= op_b_reg;
      ex_mem.rd         <= id_ex.rd;
      ex_mem.reg_write  <= id_ex.reg_write;
      ex_mem.mem_read   <= id_ex.mem_read;
      ex_mem.mem_write  <= id_ex.mem_write;

      mem_wb.result     <= mem_result;
      mem_wb.rd         <= ex_mem.rd;
      mem_wb.reg_write  <= ex_mem.reg_write;

      if (wb_we && wb_rd != 5'd0)
        regs[wb_rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_riscv_pipe_top.sv
// Self-checking bench for riscv_pipe_top: an instruction-level ISA model
// predicts the ordered stream of register write-backs and the final register
// file; directed programs plus literal expectations pin the model.
module tb_riscv_pipe_top;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_pipe_top #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clk(clk),
    .rst(rst)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] prog [0:63];
  int unsigned plen;
  logic [31:0] mreg [0:31];
  logic [31:0] mdm  [0:255];
  logic [36:0] exp_q [$];
  logic        checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] r_ins(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] i_ins(input int f3, input int rd, input int rs1, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'h13};
  endfunction
  function automatic logic [31:0] lw_ins(input int rd, input int rs1, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[11:0], 5'(rs1), 3'd2, 5'(rd), 7'h03};
  endfunction
  function automatic logic [31:0] sw_ins(input int rs2, input int rs1, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[11:5], 5'(rs2), 5'(rs1), 3'd2, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_ins(input int f3, input int rs1, input int rs2, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] jal_ins(input int rd, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6f};
  endfunction
  function automatic logic [31:0] lui_ins(input int rd, input int imm20);
    logic [31:0] im;
    im = imm20;
    return {im[19:0], 5'(rd), 7'h37};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return i_ins(0, rd, rs1, imm);
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- ISA model ----------------
  task automatic run_model();
    logic [31:0] pc, ins, a, b, res, npc, immi, imms, immb, immj, addr;
    logic [4:0]  rd;
    logic        wr;
    exp_q.delete();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    pc = '0;
    for (int unsigned n = 0; n < 200; n++) begin
      if ((pc >> 2) >= plen) break;
      ins  = prog[pc >> 2];
      a    = mreg[ins[19:15]];
      b    = mreg[ins[24:20]];
      rd   = ins[11:7];
      immi = {{20{ins[31]}}, ins[31:20]};
      imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      immj = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      wr   = 1'b0;
      res  = '0;
      npc  = pc + 32'd4;
      case (ins[6:0])
        7'h33: begin
          wr = 1'b1;
          case ({ins[31:25], ins[14:12]})
            10'h000: res = a + b;
            10'h100: res = a - b;
            10'h001: res = a << b[4:0];
            10'h002: res = {31'b0, $signed(a) < $signed(b)};
            10'h004: res = a ^ b;
            10'h005: res = a >> b[4:0];
            10'h105: res = $unsigned($signed(a) >>> b[4:0]);
            10'h006: res = a | b;
            10'h007: res = a & b;
            default: wr = 1'b0;
          endcase
        end
        7'h13: begin
          wr = 1'b1;
          case (ins[14:12])
            3'd0:    res = a + immi;
            3'd2:    res = {31'b0, $signed(a) < $signed(immi)};
            3'd4:    res = a ^ immi;
            3'd6:    res = a | immi;
            3'd7:    res = a & immi;
            default: wr = 1'b0;
          endcase
        end
        7'h03: if (ins[14:12] == 3'd2) begin
          addr = (a + immi) >> 2;
          res  = mdm[addr[7:0]];
          wr   = 1'b1;
        end
        7'h23: if (ins[14:12] == 3'd2) begin
          addr = (a + imms) >> 2;
          mdm[addr[7:0]] = b;
        end
        7'h63: begin
          if ((ins[14:12] == 3'd0 && a == b) || (ins[14:12] == 3'd1 && a != b))
            npc = pc + immb;
        end
        7'h6f: begin
          wr  = 1'b1;
          res = pc + 32'd4;
          npc = pc + immj;
        end
        7'h37: begin
          wr  = 1'b1;
          res = {ins[31:12], 12'b0};
        end
        default: ;
      endcase
      if (wr && rd != 5'd0) begin
        mreg[rd] = res;
        exp_q.push_back({rd, res});
      end
      pc = npc;
    end
  endtask

  // ---------------- write-back stream compare ----------------
  logic [36:0] wb_exp;
  always @(negedge clk) begin
    if (checking && !rst && dut.wb_we && dut.wb_rd != 5'd0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_extra: got x%0d=%h expected no write", dut.wb_rd, dut.wb_data);
      end else begin
        wb_exp = exp_q.pop_front();
        chk("wb_rd", {27'b0, dut.wb_rd}, {27'b0, wb_exp[36:32]});
        chk("wb_data", dut.wb_data, wb_exp[31:0]);
      end
    end
  end

  // ---------------- scenario helpers ----------------
  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Loads prog into INST1 (rest NOP), holds rst for two edges, checks reset
  // state, runs the model and releases reset just after an active edge.
  task automatic load_and_reset();
    int unsigned nz;
    checking = 1'b0;
    rst = 1'b1;
    for (int unsigned i = 0; i < 256; i++)
      dut.INST1.mem[i] = (i < plen) ? prog[i] : NOP;
    step(2);
    chk("reset_pc", dut.pc, 32'h0);
    nz = 0;
    for (int unsigned i = 0; i < 32; i++)
      if (dut.regs[i] != 32'h0) nz++;
    chk("reset_regs_nonzero", nz, 32'h0);
    run_model();
    rst = 1'b0;
    checking = 1'b1;
  endtask

  task automatic finish_scn(input string tag);
    step(30);
    chk({tag, "_wb_pending"}, exp_q.size(), 32'h0);
    for (int unsigned i = 1; i < 32; i++)
      chk($sformatf("%s_x%0d", tag, i), dut.regs[i], mreg[i]);
    checking = 1'b0;
  endtask

  // ---------------- directed programs ----------------
  initial begin
    // Reset + first instruction: x1 lands on the 5th edge after release
    prog[0] = addi(1, 0, 5); plen = 1;
    load_and_reset();
    step(4);
    chk("rst_x1_edge4", dut.regs[1], 32'h0);
    step(1);
    chk("rst_x1_edge5", dut.regs[1], 32'd5);
    chk("model_rst_x1", mreg[1], 32'd5);
    finish_scn("rst");

    // EX/MEM beats MEM/WB
    prog[0] = addi(1, 0, 1); prog[1] = addi(1, 0, 2); prog[2] = r_ins(0, 0, 2, 1, 1); plen = 3;
    load_and_reset();
    chk("model_fwdprio_x2", mreg[2], 32'd4);
    finish_scn("fwdprio");
    chk("fwdprio_x2", dut.regs[2], 32'd4);

    // MEM/WB forwarding
    prog[0] = addi(3, 0, 7); prog[1] = NOP; prog[2] = r_ins(0, 0, 4, 3, 3); plen = 3;
    load_and_reset();
    finish_scn("memwb");
    chk("memwb_x4", dut.regs[4], 32'd14);

    // Load-use: ADD at index 3 writes one edge late (edge 9, not 8)
    prog[0] = addi(5, 0, 9); prog[1] = sw_ins(5, 0, 0); prog[2] = lw_ins(6, 0, 0);
    prog[3] = r_ins(0, 0, 7, 6, 6); plen = 4;
    load_and_reset();
    step(8);
    chk("loaduse_x7_edge8", dut.regs[7], 32'h0);
    step(1);
    chk("loaduse_x7_edge9", dut.regs[7], 32'd18);
    finish_scn("loaduse");

    // Taken branch flushes two younger instructions
    prog[0] = addi(8, 0, 1); prog[1] = b_ins(0, 8, 8, 12); prog[2] = addi(9, 0, 1);
    prog[3] = addi(9, 0, 2); prog[4] = addi(10, 0, 3); plen = 5;
    load_and_reset();
    chk("model_branch_x9", mreg[9], 32'h0);
    finish_scn("branch");
    chk("branch_x9", dut.regs[9], 32'h0);
    chk("branch_x10", dut.regs[10], 32'd3);

    // JAL links PC+4 and skips PC 4
    prog[0] = jal_ins(1, 8); prog[1] = addi(2, 0, 5); prog[2] = addi(3, 0, 3); plen = 3;
    load_and_reset();
    finish_scn("jal");
    chk("jal_x1", dut.regs[1], 32'd4);
    chk("jal_x2", dut.regs[2], 32'h0);
    chk("jal_x3", dut.regs[3], 32'd3);

    // ALU coverage, WB bypass (distance 3), unsupported encodings, SW->LW
    prog[0]  = lui_ins(11, 32'h80000);
    prog[1]  = addi(12, 0, -3);
    prog[2]  = addi(13, 0, 4);
    prog[3]  = r_ins(32, 5, 14, 11, 13);
    prog[4]  = r_ins(0, 5, 15, 11, 13);
    prog[5]  = r_ins(0, 2, 16, 11, 13);
    prog[6]  = i_ins(2, 17, 13, -1);
    prog[7]  = r_ins(32, 0, 18, 0, 12);
    prog[8]  = r_ins(0, 0, 19, 11, 11);
    prog[9]  = i_ins(4, 20, 12, 255);
    prog[10] = b_ins(1, 13, 13, 8);
    prog[11] = r_ins(0, 1, 21, 13, 13);
    prog[12] = 32'hFFFF_FFFF;
    prog[13] = i_ins(1, 29, 13, 1);
    prog[14] = r_ins(0, 0, 22, 21, 0);
    prog[15] = i_ins(6, 23, 0, 5);
    prog[16] = i_ins(7, 24, 12, 240);
    prog[17] = sw_ins(12, 13, 8);
    prog[18] = lw_ins(25, 0, 12);
    prog[19] = r_ins(0, 7, 26, 12, 13);
    prog[20] = r_ins(0, 6, 27, 12, 13);
    prog[21] = r_ins(0, 4, 28, 12, 13);
    plen = 22;
    load_and_reset();
    chk("model_mix_x14", mreg[14], 32'hF800_0000);
    chk("model_mix_x20", mreg[20], 32'hFFFF_FF02);
    chk("model_mix_x28", mreg[28], 32'hFFFF_FFF9);
    finish_scn("mix");
    chk("mix_x14_sra", dut.regs[14], 32'hF800_0000);
    chk("mix_x15_srl", dut.regs[15], 32'h0800_0000);
    chk("mix_x16_slt", dut.regs[16], 32'd1);
    chk("mix_x18_sub", dut.regs[18], 32'd3);
    chk("mix_x22_bypass", dut.regs[22], 32'd64);
    chk("mix_x24_andi", dut.regs[24], 32'h0000_00F0);
    chk("mix_x25_lw", dut.regs[25], 32'hFFFF_FFFD);

    // Mid-program reset: SW sits in EX/MEM at the reset edge and must not
    // write; dmem word 0 still holds 9 from the load-use program.
    prog[0] = sw_ins(0, 0, 0); prog[1] = addi(1, 0, 7); prog[2] = addi(2, 0, 8); plen = 3;
    load_and_reset();
    checking = 1'b0;
    step(3);
    rst = 1'b1;
    step(3);
    chk("abandon_dmem0", dut.dmem[0], 32'd9);
    chk("abandon_x1", dut.regs[1], 32'h0);
    chk("abandon_pc", dut.pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
